// File: rtl/c2c_r_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : c2c_r_arbiter                                                    |
// | Brief   : Two-master (fetch I / load D) to one c2c_r read slave arbiter.   |
// |           Data has priority, MAX_WAIT bounds fetch starvation.             |
// |           Optional ARB_STATS_EN adds stat_conflicts / stat_starve.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module c2c_r_arbiter #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_re,
   input  logic [XLEN-1:0] i_addr,
   input  logic [3:0]      i_sel,
   output logic [XLEN-1:0] i_data,
   output logic            i_ack,
   input  logic            d_re,
   input  logic [XLEN-1:0] d_addr,
   input  logic [3:0]      d_sel,
   output logic [XLEN-1:0] d_data,
   output logic            d_ack,
   output logic            m_re,
   output logic [XLEN-1:0] m_addr,
   output logic [3:0]      m_sel,
   input  logic [XLEN-1:0] m_data,
   input  logic            m_ack
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]     stat_conflicts,
   output logic [31:0]     stat_starve
`endif
);

   localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_I = 2'd1,
      ST_OWN_D = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_wait_cnt;
   logic [3:0] w_wait_nxt;
   logic       w_idle;
   logic       w_conflict;
   logic       w_forced;
   logic       w_grant_i;
   logic       w_grant_d;

   always_comb begin
      w_idle     = (r_state == ST_IDLE);
      w_conflict = w_idle & i_re & d_re;
      w_forced   = w_conflict & (r_wait_cnt == c_max_wait);
      w_grant_d  = w_idle & d_re & ~w_forced;
      w_grant_i  = w_idle & i_re & ~w_grant_d;
   end

   // Outputs are purely combinational; reset forces every output low at once.
   always_comb begin
      w_state_nxt = r_state;
      m_re        = 1'b0;
      m_addr      = '0;
      m_sel       = '0;
      i_ack       = 1'b0;
      i_data      = '0;
      d_ack       = 1'b0;
      d_data      = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_d) begin
               m_re   = 1'b1;
               m_addr = d_addr;
               m_sel  = d_sel;
               if (m_ack) begin
                  d_ack  = 1'b1;
                  d_data = m_data;
               end else begin
                  w_state_nxt = ST_OWN_D;
               end
            end else if (w_grant_i) begin
               m_re   = 1'b1;
               m_addr = i_addr;
               m_sel  = i_sel;
               if (m_ack) begin
                  i_ack  = 1'b1;
                  i_data = m_data;
               end else begin
                  w_state_nxt = ST_OWN_I;
               end
            end
         end
         ST_OWN_I: begin
            m_re   = 1'b1;
            m_addr = i_addr;
            m_sel  = i_sel;
            if (m_ack) begin
               w_state_nxt = ST_IDLE;
               // An aborted owner (re dropped) never sees its ack.
               if (i_re) begin
                  i_ack  = 1'b1;
                  i_data = m_data;
               end
            end
         end
         ST_OWN_D: begin
            m_re   = 1'b1;
            m_addr = d_addr;
            m_sel  = d_sel;
            if (m_ack) begin
               w_state_nxt = ST_IDLE;
               if (d_re) begin
                  d_ack  = 1'b1;
                  d_data = m_data;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (reset) begin
         m_re   = 1'b0;
         m_addr = '0;
         m_sel  = '0;
         i_ack  = 1'b0;
         i_data = '0;
         d_ack  = 1'b0;
         d_data = '0;
      end
   end

   always_comb begin
      w_wait_nxt = r_wait_cnt;
      if (w_idle) begin
         if (w_grant_i || !i_re) begin
            w_wait_nxt = 4'd0;
         end else if (w_grant_d && (r_wait_cnt != c_max_wait)) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

`ifdef ARB_STATS_EN
   logic [31:0] r_stat_conflicts;
   logic [31:0] r_stat_starve;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_conflicts <= '0;
         r_stat_starve    <= '0;
      end else begin
         if (w_conflict) r_stat_conflicts <= r_stat_conflicts + 32'd1;
         if (w_forced)   r_stat_starve    <= r_stat_starve + 32'd1;
      end
   end

   assign stat_conflicts = r_stat_conflicts;
   assign stat_starve    = r_stat_starve;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c2c_r_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_c2c_r_arbiter                                                 |
// | Brief   : Scoreboard bench for c2c_r_arbiter with a latency-programmable   |
// |           slave model and directed fetch/load master sequences.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_c2c_r_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_re, d_re, m_re, i_ack, d_ack, m_ack;
   logic [31:0] i_addr, d_addr, m_addr, i_data, d_data, m_data;
   logic [3:0]  i_sel, d_sel, m_sel;
`ifdef ARB_STATS_EN
   logic [31:0] stat_conflicts, stat_starve;
`endif

   c2c_r_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .i_re(i_re), .i_addr(i_addr), .i_sel(i_sel), .i_data(i_data), .i_ack(i_ack),
      .d_re(d_re), .d_addr(d_addr), .d_sel(d_sel), .d_data(d_data), .d_ack(d_ack),
      .m_re(m_re), .m_addr(m_addr), .m_sel(m_sel), .m_data(m_data), .m_ack(m_ack)
`ifdef ARB_STATS_EN
      , .stat_conflicts(stat_conflicts), .stat_starve(stat_starve)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic        ack_i_seen = 1'b0;
   logic        ack_d_seen = 1'b0;

   // Slave model: ack on the slv_lat-th cycle of a held request (0 = same cycle).
   int          slv_lat   = 1;
   int          slv_cnt   = 0;
   bit          slv_en    = 1'b1;
   bit          slv_force = 1'b0;

   logic [31:0] i_list[8];
   logic [31:0] d_list[8];
   int          i_n = 0, i_idx = 0, d_n = 0, d_idx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] slv_data(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0000_0013;
      if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(negedge clk) begin
      if (slv_en) begin
         if (m_re) begin
            if (slv_cnt == slv_lat) begin
               m_ack   = 1'b1;
               m_data  = slv_data(m_addr);
               slv_cnt = 0;
            end else begin
               m_ack   = 1'b0;
               m_data  = 32'h0;
               slv_cnt = slv_cnt + 1;
            end
         end else begin
            m_ack   = 1'b0;
            m_data  = 32'h0;
            slv_cnt = 0;
         end
      end else begin
         m_ack  = slv_force;
         m_data = 32'h0000_1234;
      end
   end

   // Monitor: pops one expected completion per observed ack.
   always begin
      @(posedge clk);
      #8;
      ack_i_seen = i_ack;
      ack_d_seen = d_ack;
      if (i_ack || d_ack) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", {30'h0, i_ack, d_ack}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_port_d", {31'h0, d_ack}, {31'h0, e.is_d});
            check("ack_port_i", {31'h0, i_ack}, {31'h0, !e.is_d});
            check("ack_data", d_ack ? d_data : i_data, e.data);
            check("nonowner_data", d_ack ? i_data : d_data, 32'h0);
         end
      end
   end

   task automatic push(input bit is_d, input logic [31:0] data);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic masters_cycle();
      @(posedge clk);
      #1;
      if (ack_i_seen) i_idx++;
      if (ack_d_seen) d_idx++;
      i_re   = (i_idx < i_n);
      i_addr = i_re ? i_list[i_idx] : 32'h0;
      d_re   = (d_idx < d_n);
      d_addr = d_re ? d_list[d_idx] : 32'h0;
   endtask

   task automatic run(input int maxc);
      int c = 0;
      while (((i_idx < i_n) || (d_idx < d_n)) && (c < maxc)) begin
         masters_cycle();
         c++;
      end
      check("run_timeout", {31'h0, (i_idx < i_n) || (d_idx < d_n)}, 32'h0);
   endtask

   task automatic load(input int ni, input int nd);
      i_n = ni; i_idx = 0; d_n = nd; d_idx = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      i_re = 0; i_addr = 0; i_sel = 4'hF;
      d_re = 1; d_addr = 32'h9999; d_sel = 4'h3;
      repeat (3) @(posedge clk);
      #3;
      check("rst_m_re", {31'h0, m_re}, 32'h0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_m_sel", {28'h0, m_sel}, 32'h0);
      check("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
      check("rst_data", i_data | d_data, 32'h0);
      d_re = 0; d_addr = 0;
      @(posedge clk); #1 reset = 1'b0;

      // Single fetch, slave acks two cycles after the grant.
      slv_lat = 2;
      i_list[0] = 32'h100; load(1, 0);
      push(0, 32'h0000_0013);
      for (int k = 0; k < 3; k++) begin
         masters_cycle();
         #2;
         check("fetch_m_addr", m_addr, 32'h100);
         check("fetch_m_re", {31'h0, m_re}, 32'h1);
      end
      check("fetch_m_sel", {28'h0, m_sel}, 32'hF);
      run(10);

      // Zero-wait load completes without leaving IDLE.
      slv_lat = 0;
      d_list[0] = 32'h2000; load(0, 1);
      push(1, 32'hDEAD_BEEF);
      run(10);
      #2;
      check("zw_idle_m_re", {31'h0, m_re}, 32'h0);

      // Contention: data first, fetch next.
      slv_lat = 1;
      i_list[0] = 32'h408; d_list[0] = 32'h3000; load(1, 1);
      push(1, 32'hA5A5_3000);
      push(0, 32'hA5A5_0408);
      masters_cycle();
      #2;
      check("cont_m_addr", m_addr, 32'h3000);
      run(20);

      // Starvation: D,D,D,D,I,D,D,I.
      i_list[0] = 32'h400; i_list[1] = 32'h404;
      for (int k = 0; k < 6; k++) d_list[k] = 32'h3100 + 32'(4 * k);
      load(2, 6);
      push(1, 32'hA5A5_3100); push(1, 32'hA5A5_3104);
      push(1, 32'hA5A5_3108); push(1, 32'hA5A5_310C);
      push(0, 32'hA5A5_0400);
      push(1, 32'hA5A5_3110); push(1, 32'hA5A5_3114);
      push(0, 32'hA5A5_0404);
      run(60);

      // Lock: fetch owns the slave while load arrives.
      slv_lat = 3;
      i_list[0] = 32'h600; d_list[0] = 32'h5000; load(1, 0);
      push(0, 32'hA5A5_0600);
      push(1, 32'hA5A5_5000);
      masters_cycle();
      d_n = 1;
      for (int k = 0; k < 3; k++) begin
         masters_cycle();
         #2;
         check("lock_m_addr", m_addr, 32'h600);
      end
      run(20);

      // Abort: fetch drops re while owning; its ack is swallowed.
      slv_lat = 2;
      i_list[0] = 32'h500; load(1, 0);
      masters_cycle();
      i_n = 0;
      masters_cycle();
      #2;
      check("abort_m_re_held", {31'h0, m_re}, 32'h1);
      masters_cycle();
      masters_cycle();
      #2;
      check("abort_idle_m_re", {31'h0, m_re}, 32'h0);

      // Reset while data owns the slave.
      slv_lat = 5;
      d_list[0] = 32'h7000; load(0, 1);
      masters_cycle();
      masters_cycle();
      #2;
      check("rmid_m_addr", m_addr, 32'h7000);
      @(posedge clk); #1;
      reset = 1'b1;
      #2;
      check("rmid_m_re", {31'h0, m_re}, 32'h0);
      check("rmid_d_ack", {31'h0, d_ack}, 32'h0);
      check("rmid_m_addr0", m_addr, 32'h0);
      load(0, 0);
      masters_cycle();
      @(posedge clk); #1 reset = 1'b0;
      slv_en = 1'b0;
      slv_force = 1'b1;
      @(posedge clk); #4;
      check("late_ack", {30'h0, i_ack, d_ack}, 32'h0);
      check("late_m_re", {31'h0, m_re}, 32'h0);
      @(posedge clk); #1 slv_force = 1'b0;
      repeat (2) @(posedge clk);
      slv_en = 1'b1;

      repeat (3) @(posedge clk);
      check("sb_drain", sb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
